// File: rtl/pot_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pot_scan_ctrl
// Purpose  : Round-robin A2D scan of six pots into shadow registers, with the
//            full set committed to the core outputs on a frame-strobe edge.
// Revision : 1.0  initial release
// ============================================================================
module pot_scan_ctrl #(
    parameter int GAP_CYC = 64,
    parameter int TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_strb,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] VOL_pot,
    output logic        scan_done,
    output logic        a2d_err
);

    localparam int                 c_GAP_W    = $clog2(GAP_CYC + 1);
    localparam int                 c_TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYC - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [2:0]         r_idx;
    logic [2:0]         r_chnnl;
    logic               r_pend;
    logic               r_frm_q1;
    logic               r_frm_q2;
    logic               r_strt_cnv;
    logic               r_scan_done;
    logic               r_a2d_err;
    logic [11:0]        r_shadow [6];
    logic [11:0]        r_pot    [6];
    logic               w_capture;
    logic               w_timeout;
    logic               w_wrap;
    logic               w_commit;

    function automatic logic [2:0] chan_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd1;
            3'd1:    return 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            3'd5:    return 3'd7;
            default: return 3'd1;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_GAP:   if (r_gap_cnt == c_GAP_LAST) w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A completion in the final timeout cycle still wins.
                if (cnv_cmplt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_STORE;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: w_state_nxt = S_GAP;
            default: w_state_nxt = S_GAP;
        endcase
    end

    assign w_wrap   = (r_state == S_STORE) && (r_idx == c_IDX_LAST);
    assign w_commit = r_frm_q1 && !r_frm_q2 && r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_GAP;
            r_gap_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_idx       <= 3'd0;
            r_chnnl     <= 3'd1;
            r_pend      <= 1'b0;
            r_frm_q1    <= 1'b0;
            r_frm_q2    <= 1'b0;
            r_strt_cnv  <= 1'b0;
            r_scan_done <= 1'b0;
            r_a2d_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap_cnt   <= (r_state == S_GAP)  ? r_gap_cnt + 1'b1 : '0;
            r_tmo_cnt   <= (r_state == S_WAIT) ? r_tmo_cnt + 1'b1 : '0;
            r_frm_q1    <= frm_strb;
            r_frm_q2    <= r_frm_q1;
            r_strt_cnv  <= (r_state == S_REQ);
            r_scan_done <= w_wrap;
            if (r_state == S_GAP && w_state_nxt == S_REQ) r_chnnl <= chan_of(r_idx);
            if (r_state == S_STORE) r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
            // A wrap landing on a commit keeps pend set for the new scan.
            if (w_wrap)        r_pend <= 1'b1;
            else if (w_commit) r_pend <= 1'b0;
            if (w_timeout)     r_a2d_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_shadow[i] <= 12'h000;
                r_pot[i]    <= 12'h000;
            end
        end else begin
            if (w_capture) r_shadow[r_idx] <= res;
            if (w_commit) begin
                for (int i = 0; i < 6; i++) r_pot[i] <= r_shadow[i];
            end
        end
    end

    assign strt_cnv  = r_strt_cnv;
    assign chnnl     = r_chnnl;
    assign scan_done = r_scan_done;
    assign a2d_err   = r_a2d_err;
    assign LP_pot    = r_pot[0];
    assign B1_pot    = r_pot[1];
    assign B2_pot    = r_pot[2];
    assign B3_pot    = r_pot[3];
    assign HP_pot    = r_pot[4];
    assign VOL_pot   = r_pot[5];

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pot_scan_ctrl
// Purpose  : Self-checking bench for pot_scan_ctrl with a transaction-level
//            model of the scan, shadow and commit behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_pot_scan_ctrl;

    localparam int GAP_CYC = 64;
    localparam int TMO_CYC = 1024;

    logic        clk;
    logic        rst_n;
    logic        frm_strb;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;
    logic        scan_done;
    logic        a2d_err;

    pot_scan_ctrl #(.GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frm_strb  (frm_strb),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .LP_pot    (LP_pot),
        .B1_pot    (B1_pot),
        .B2_pot    (B2_pot),
        .B3_pot    (B3_pot),
        .HP_pot    (HP_pot),
        .VOL_pot   (VOL_pot),
        .scan_done (scan_done),
        .a2d_err   (a2d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dly;
        logic [11:0] val;
        logic [2:0]  exp_ch;
        bit          frm_after;
    } vec_t;

    vec_t        tbl [6];
    logic [2:0]  ch_map [6];
    logic [11:0] m_sh  [6];
    logic [11:0] m_out [6];
    bit          m_pend;
    bit          m_err;
    int          m_idx;
    int          t_end;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [71:0] dut_pots();
        return {VOL_pot, HP_pot, B3_pot, B2_pot, B1_pot, LP_pot};
    endfunction

    function automatic logic [71:0] model_pots();
        return {m_out[5], m_out[4], m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i]  = 12'h000;
            m_out[i] = 12'h000;
        end
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_idx  = 0;
    endtask

    task automatic wait_strt();
        int n;
        n = 0;
        while (strt_cnv !== 1'b1 && n < GAP_CYC + 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (strt_cnv !== 1'b1) begin
            n_chk++;
            $display("FAIL strt_wait: strt_cnv still %b after %0d cycles", strt_cnv, n);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    endtask

    // One conversion: answer after dly cycles, or stay silent to force a timeout.
    // With sim set, the frame strobe rises together with the completion so that
    // its commit lands on the STORE cycle.
    task automatic do_conv(input int dly, input bit silent, input bit sim,
                           input logic [11:0] val, input logic [2:0] exp_ch);
        bit wrap;
        wait_strt();
        chk("gap_len", 72'(cyc - t_end), 72'(GAP_CYC + 1));
        chk("chnnl_req", 72'(chnnl), 72'(exp_ch));
        chk("err_sticky", 72'(a2d_err), 72'(m_err));
        @(posedge clk); #1;
        chk("strt_one_cycle", 72'(strt_cnv), 72'(0));
        if (silent) begin
            repeat (TMO_CYC - 2) begin @(posedge clk); #1; end
            chk("err_before_tmo", 72'(a2d_err), 72'(m_err));
            @(posedge clk); #1;
            chk("err_at_tmo", 72'(a2d_err), 72'(1));
            m_err = 1'b1;
        end else begin
            repeat (dly - 1) begin @(posedge clk); #1; end
            chk("chnnl_hold", 72'(chnnl), 72'(exp_ch));
            cnv_cmplt = 1'b1;
            res       = val;
            if (sim) frm_strb = 1'b1;
            @(posedge clk); #1;
            cnv_cmplt = 1'b0;
            res       = 12'($urandom);
            m_sh[m_idx] = val;
            if (sim) chk("sim_pre", dut_pots(), model_pots());
        end
        @(posedge clk); #1;
        wrap = (m_idx == 5);
        if (sim && m_pend) begin
            for (int i = 0; i < 6; i++) m_out[i] = m_sh[i];
        end
        if (wrap) m_pend = 1'b1;
        chk("scan_done", 72'(scan_done), 72'(wrap));
        if (sim) begin
            chk("sim_commit", dut_pots(), model_pots());
            frm_strb = 1'b0;
        end
        m_idx = wrap ? 0 : m_idx + 1;
        t_end = cyc;
    endtask

    task automatic frm_edge(input bit hold);
        frm_strb = 1'b1;
        @(posedge clk); #1;
        chk("commit_latency", dut_pots(), model_pots());
        @(posedge clk); #1;
        if (m_pend) begin
            for (int i = 0; i < 6; i++) m_out[i] = m_sh[i];
            m_pend = 1'b0;
        end
        chk("commit", dut_pots(), model_pots());
        if (!hold) begin
            frm_strb = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic stray_cmplt(input logic [11:0] val);
        cnv_cmplt = 1'b1;
        res       = val;
        @(posedge clk); #1;
        cnv_cmplt = 1'b0;
        chk("stray_ignored", dut_pots(), model_pots());
    endtask

    initial begin
        logic [11:0] b2_old;
        logic [11:0] v;

        ch_map = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        for (int i = 0; i < 6; i++) begin
            tbl[i].dly       = 20;
            tbl[i].val       = 12'(12'h100 + i);
            tbl[i].frm_after = (i == 1 || i == 3);
        end
        tbl[0].exp_ch = 3'd1; tbl[1].exp_ch = 3'd0; tbl[2].exp_ch = 3'd4;
        tbl[3].exp_ch = 3'd2; tbl[4].exp_ch = 3'd3; tbl[5].exp_ch = 3'd7;

        rst_n     = 1'b0;
        frm_strb  = 1'b0;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pots", dut_pots(), 72'h0);
        chk("rst_strt", 72'(strt_cnv), 72'(0));
        chk("rst_done", 72'(scan_done), 72'(0));
        chk("rst_err", 72'(a2d_err), 72'(0));
        chk("rst_chnnl", 72'(chnnl), 72'(1));
        rst_n = 1'b1;
        t_end = cyc;

        // Normal scan with strobes mid-scan that must not commit.
        for (int i = 0; i < 6; i++) begin
            do_conv(tbl[i].dly, 1'b0, 1'b0, tbl[i].val, tbl[i].exp_ch);
            if (tbl[i].frm_after) frm_edge(1'b0);
        end
        frm_edge(1'b0);
        chk("scan1_values", dut_pots(), 72'h105_104_103_102_101_100);

        // Strobe held high across a whole scan commits nothing new.
        frm_edge(1'b1);
        for (int i = 0; i < 6; i++)
            do_conv($urandom_range(1, 150), 1'b0, 1'b0, 12'($urandom), ch_map[m_idx]);
        chk("held_no_commit", dut_pots(), 72'h105_104_103_102_101_100);
        frm_strb = 1'b0;
        @(posedge clk); #1;
        frm_edge(1'b0);

        // Randomized scans with stray completions and random commits.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 6; i++) begin
                do_conv($urandom_range(1, 150), 1'b0, 1'b0, 12'($urandom), ch_map[m_idx]);
                if ($urandom_range(0, 3) == 0) stray_cmplt(12'hFFF);
                if ($urandom_range(0, 2) == 0) frm_edge(1'b0);
            end
        end

        // Commit coinciding with a wrap: uncommitted scan, then strobe on wrap.
        for (int i = 0; i < 6; i++)
            do_conv($urandom_range(1, 60), 1'b0, 1'b0, 12'($urandom), ch_map[m_idx]);
        for (int i = 0; i < 6; i++)
            do_conv($urandom_range(1, 60), 1'b0, (i == 5), 12'($urandom), ch_map[m_idx]);
        v = 12'($urandom) ^ m_sh[0] ^ 12'h001;
        if (v == m_sh[0]) v = ~v;
        do_conv(20, 1'b0, 1'b0, v, ch_map[m_idx]);
        frm_edge(1'b0);
        chk("pend_kept", 72'(LP_pot), 72'(v));

        // Timeout on B2, scan carries on with B3.
        do_conv(20, 1'b0, 1'b0, 12'($urandom), 3'd0);
        b2_old = m_sh[2];
        do_conv(0, 1'b1, 1'b0, 12'h000, 3'd4);
        do_conv(20, 1'b0, 1'b0, 12'($urandom), 3'd2);
        do_conv(20, 1'b0, 1'b0, 12'($urandom), 3'd3);
        do_conv(20, 1'b0, 1'b0, 12'($urandom), 3'd7);
        frm_edge(1'b0);
        chk("b2_kept", 72'(B2_pot), 72'(b2_old));

        // Reset in the middle of a conversion, then a stray completion.
        wait_strt();
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_pots", dut_pots(), 72'h0);
        chk("midrst_err", 72'(a2d_err), 72'(0));
        chk("midrst_chnnl", 72'(chnnl), 72'(1));
        chk("midrst_strt", 72'(strt_cnv), 72'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        t_end = cyc;
        repeat (5) begin @(posedge clk); #1; end
        stray_cmplt(12'hABC);
        chk("stray_err", 72'(a2d_err), 72'(0));
        for (int i = 0; i < 6; i++)
            do_conv($urandom_range(1, 100), 1'b0, 1'b0, 12'($urandom), ch_map[m_idx]);
        frm_edge(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        n_chk++;
        $display("FAIL watchdog: simulation ran past its time limit");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pot_scan_ctrl.md
POT_SCAN_CTRL -- requirements
Module: pot_scan_ctrl

Interface
REQ-001 Parameter GAP_CYC, default 64: idle clk cycles between the end of one conversion and the next strt_cnv.
REQ-002 Parameter TMO_CYC, default 1024: clk cycles allowed from strt_cnv to cnv_cmplt before timeout.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 frm_strb  input  1  sample-frame boundary, level input; its rising edge is the commit point.
REQ-006 strt_cnv  output  1  one-cycle request to the A2D interface.
REQ-007 chnnl  output  3  A2D channel select, held stable from strt_cnv through cnv_cmplt.
REQ-008 cnv_cmplt  input  1  one-cycle completion pulse from the A2D interface.
REQ-009 res  input  12  conversion result, valid in the cycle cnv_cmplt=1.
REQ-010 LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot  output  12 each  committed pot values to core.
REQ-011 scan_done  output  1  one-cycle pulse when all six shadow values have been refreshed.
REQ-012 a2d_err  output  1  sticky timeout flag.

Function
REQ-013 Scan order: index 0..5 = LP, B1, B2, B3, HP, VOL; chnnl map 1, 0, 4, 2, 3, 7; after index 5, wrap to 0.
REQ-014 FSM states: GAP, REQ, WAIT, STORE.
REQ-015 GAP: count GAP_CYC cycles, then go to REQ.
REQ-016 REQ: assert strt_cnv for exactly one cycle with chnnl set to the current index's channel, then go to WAIT.
REQ-017 WAIT: on cnv_cmplt, capture res into that index's shadow register, then go to STORE.
REQ-018 WAIT: if TMO_CYC cycles elapse with no cnv_cmplt, set a2d_err, leave the shadow register unchanged, then go to STORE.
REQ-019 STORE: advance the index; go to GAP; on the 5->0 wrap, pulse scan_done and set the internal pend flag.
REQ-020 cnv_cmplt outside WAIT is ignored.
REQ-021 Detect the frm_strb rising edge with a registered copy, so frm_strb held high commits once.
REQ-022 Commit: on a frm_strb rising edge with pend=1, copy all six shadows to the outputs in one cycle and clear pend.
REQ-023 Outputs change only on commit.
REQ-024 If a commit and the pend-set from a new wrap occur in the same cycle, the commit uses the shadows as they stood before that cycle and pend stays 1.
REQ-025 A frm_strb edge with pend=0 has no effect.
REQ-026 Commit latency: outputs update on the clk edge after the cycle in which the frm_strb rising edge is registered.
REQ-027 chnnl changes only when entering REQ.
REQ-028 a2d_err clears only on reset.
REQ-029 res is unsigned and is passed through unmodified; no arithmetic is applied.

Reset
REQ-030 On rst_n low, immediately:
- state=GAP, gap count=0, index=0, pend=0;
- strt_cnv=0, scan_done=0, a2d_err=0, chnnl=3'd1;
- all shadow and output pots = 12'h000.
REQ-031 Reset asserted mid-conversion abandons the conversion; a cnv_cmplt arriving after rst_n release is ignored unless the FSM is in WAIT.
REQ-032 The first strt_cnv after reset release occurs GAP_CYC+1 cycles after the first clk edge.

Verification
REQ-033 Normal scan: A2D model returns 12'h100+index with cnv_cmplt 20 cycles after each strt_cnv; pulse frm_strb after scan_done.
- Required: chnnl sequence 1,0,4,2,3,7.
- Required: LP_pot..VOL_pot = 0x100..0x105 after commit.
REQ-034 Commit gating: frm_strb edges during the first scan leave all outputs 0; values appear only on the first edge after scan_done; a frm_strb held high 100 cycles commits once.
REQ-035 Timeout: A2D model silent on B2 (chnnl 4) with TMO_CYC=1024.
- Required: a2d_err=1 at cycle 1024 of WAIT.
- Required: B2 shadow keeps its old value; scan continues with chnnl 2.
REQ-036 Simultaneous events: frm_strb edge in the same cycle as the STORE wrap -> prior shadows committed, pend=1, second edge commits the new scan.
REQ-037 Reset mid-WAIT: drop rst_n for 3 cycles during a conversion, then send a stray cnv_cmplt 5 cycles after release.
- Required: all pots 0, a2d_err=0, stray pulse ignored.
- Required: next strt_cnv with chnnl=1 after GAP_CYC.
REQ-038 Spurious cnv_cmplt in GAP with res=12'hFFF -> no shadow or output change.
